instr_encoder: RTL and testbench

//   Builds 16-bit instruction words from separate fields and sends them to the

---
 rtl/instr_encoder.sv | 140 ++++++++++++++
 tb/tb_instr_encoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs instruction field sets into 16-bit words, queues them in a small FIFO
// and issues them with a minimum spacing between output handshakes.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int GAP   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_fmt,
  input  logic [3:0]                 in_op,
  input  logic [3:0]                 in_rd,
  input  logic [3:0]                 in_ext,
  input  logic [3:0]                 in_rs,
  input  logic [7:0]                 in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_word,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(GAP + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, HOLD = 2'd2} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]  level_reg, level_next;
  logic           rdy_reg;
  logic           err_reg;

  logic [15:0]    in_word;
  logic           legal;
  logic           full, accept, push, pop;

  // RI words with major opcode 0 or 8 would alias the RR/SH encodings.
  always_comb begin
    legal   = 1'b1;
    in_word = 16'h0000;
    case (in_fmt)
      2'b00: in_word = {4'h0, in_rd, in_ext, in_rs};
      2'b10: in_word = {4'h8, in_rd, in_ext, in_rs};
      2'b01: begin
        in_word = {in_op, in_rd, in_imm};
        legal   = (in_op != 4'h0) && (in_op != 4'h8);
      end
      default: legal = 1'b0;
    endcase
  end

  assign full     = (level_reg == LW'(DEPTH));
  assign in_ready = rdy_reg && !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = out_valid && out_ready;

  always_comb begin
    level_next = level_reg;
    if (push && !pop)
      level_next = level_reg + LW'(1);
    else if (!push && pop)
      level_next = level_reg - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= in_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      rdy_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
      rdy_reg   <= 1'b1;
      err_reg   <= accept && !legal;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // FSM: next state; decisions look at the post-edge level so a word pushed
  // on the deciding edge is not delayed by an extra idle cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (level_next != '0) state_next = SEND;
      end
      SEND: begin
        if (pop) begin
          if (GAP > 1) begin
            cnt_next   = CW'(GAP - 1);
            state_next = HOLD;
          end else begin
            state_next = (level_next != '0) ? SEND : IDLE;
          end
        end
      end
      HOLD: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1))
          state_next = (level_next != '0) ? SEND : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_valid = (state_reg == SEND);
    out_word  = out_valid ? mem[rd_ptr_reg] : 16'h0000;
  end

  assign err   = err_reg;
  assign level = level_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder: accepted legal field sets are
// queued as expected words and checked in order as the encoder issues them.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int GAP   = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_fmt = 2'b00;
  logic [3:0]    in_op = 4'h0, in_rd = 4'h0, in_ext = 4'h0, in_rs = 4'h0;
  logic [7:0]    in_imm = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_word;
  logic          err;
  logic [LW-1:0] level;

  instr_encoder #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_rd(in_rd), .in_ext(in_ext),
    .in_rs(in_rs), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .err(err), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;   // 0 hold low, 1 hold high, 2 random
  int n_out = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  bit          armed = 1'b0;
  bit          rdy_m = 1'b0;
  bit          err_m = 1'b0;
  int          since = GAP;

  function automatic bit is_legal(input logic [1:0] f, input logic [3:0] op);
    return (f != 2'b11) && !(f == 2'b01 && (op == 4'h0 || op == 4'h8));
  endfunction

  function automatic logic [15:0] pack(input logic [1:0] f, input logic [3:0] op,
      input logic [3:0] rd, input logic [3:0] ext, input logic [3:0] rs,
      input logic [7:0] imm);
    if (f == 2'b01) return {op, rd, imm};
    return {(f == 2'b10) ? 4'h8 : 4'h0, rd, ext, rs};
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Monitor / scoreboard: compare at the falling edge, then advance the model
  // by what the coming rising edge will do.
  always @(negedge clk) begin
    bit exp_valid;
    if (armed) begin
      exp_valid = (exp_q.size() > 0) && (since >= GAP);
      check("in_ready", {31'b0, in_ready}, {31'b0, rdy_m && (exp_q.size() != DEPTH)});
      check("level", {{(32-LW){1'b0}}, level}, exp_q.size());
      check("err", {31'b0, err}, {31'b0, err_m});
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (exp_valid)
        check("out_word", {16'b0, out_word}, {16'b0, exp_q[0]});
      else
        check("out_word_idle", {16'b0, out_word}, 32'h0);
    end
    if (rst) begin
      exp_q.delete();
      rdy_m = 1'b0;
      err_m = 1'b0;
      since = GAP;
      armed = 1'b1;
    end else if (armed) begin
      bit acc;
      acc   = in_valid && in_ready;
      err_m = acc && !is_legal(in_fmt, in_op);
      rdy_m = 1'b1;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        n_out++;
        $display("OUT #%0d word=%04h exp=%04h t=%0t", n_out, out_word, exp_q[0], $time);
        void'(exp_q.pop_front());
        since = 1;
      end else if (since < GAP) begin
        since++;
      end
      if (acc && is_legal(in_fmt, in_op))
        exp_q.push_back(pack(in_fmt, in_op, in_rd, in_ext, in_rs, in_imm));
    end
  end

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic drive(input logic [1:0] f, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] ext, input logic [3:0] rs, input logic [7:0] imm);
    in_valid = 1'b1;
    in_fmt = f; in_op = op; in_rd = rd; in_ext = ext; in_rs = rs; in_imm = imm;
  endtask

  task automatic wait_accept();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 300) begin
      $display("FAIL accept_timeout: in_ready never rose at %0t", $time);
      $fatal(1, "accept timeout");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] f, input logic [3:0] op, input logic [3:0] rd,
                      input logic [3:0] ext, input logic [3:0] rs, input logic [7:0] imm);
    drive(f, op, rd, ext, rs, imm);
    wait_accept();
  endtask

  task automatic wait_empty();
    int n;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    if (n == 500) begin
      $display("FAIL drain_timeout: queue never emptied at %0t", $time);
      $fatal(1, "drain timeout");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = 1;
    @(posedge clk); #1;

    // Basic RR, RI and an illegal RI
    send(2'b00, 4'h0, 4'h3, 4'h5, 4'h1, 8'h00);
    send(2'b01, 4'h5, 4'h2, 4'h0, 4'h0, 8'h7F);
    send(2'b01, 4'h0, 4'h1, 4'h0, 4'h0, 8'h11);
    send(2'b10, 4'h0, 4'hA, 4'h3, 4'hC, 8'h00);
    send(2'b11, 4'h4, 4'h4, 4'h4, 4'h4, 8'h44);
    wait_empty();

    // Fill while stalled, hold a fifth set, then release
    ready_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++)
      send(2'b00, 4'h0, 4'(i), 4'(i + 1), 4'(i + 2), 8'h00);
    drive(2'b01, 4'h9, 4'h7, 4'h0, 4'h0, 8'hA5);
    repeat (4) @(posedge clk);
    #1 ready_mode = 1;
    wait_accept();
    wait_empty();

    // Back-to-back queued words exercise the gap; then reset mid-HOLD
    ready_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      send(2'b10, 4'h0, 4'(i), 4'hF, 4'(i), 8'h00);
    ready_mode = 1;
    begin
      int n;
      for (n = 0; n < 50; n++) begin
        @(negedge clk);
        if (out_valid && out_ready) break;
      end
      if (n == 50) begin
        $display("FAIL issue_timeout: no output handshake at %0t", $time);
        $fatal(1, "issue timeout");
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(2'b00, 4'h0, 4'h6, 4'h6, 4'h6, 8'h00);
    wait_empty();

    // Randomized traffic with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 250; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ready_mode = 1;
    wait_empty();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
